// File: rtl/alu_exec.sv
// alu_exec: EX-stage execution unit. Single-cycle ADD/SUB/AND/XOR/SLL/SRA with
// registered result; iterative shift-add MUL over WIDTH cycles with ready_o low.
// Ports: clk_i/rst_i (async active-low), valid_i/ALUCtrl_i/data1_i/data2_i op in,
//        flush_i abort, ready_o accept-able, data_o/valid_o/zero_o registered result.
module alu_exec #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             zero_o
);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, mcand, mplier;
  logic [SHAMT_W-1:0] count;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_nxt;
  logic               alu_load, mul_start, mul_done;

  // Shifts only honour the low SHAMT_W bits of operand B.
  assign shamt = data2_i[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_SLL:  alu_res = data1_i << shamt;
      OP_SRA:  alu_res = $unsigned($signed(data1_i) >>> shamt);
      default: alu_res = '0;  // reserved code and MUL (MUL result comes from acc)
    endcase
  end

  // One shift-add step; on the final step this is the product.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  assign ready_o = (state == IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_load  = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    if (flush_i) begin
      // Flush wins over both accept and MUL completion.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              mul_start = 1'b1;
              state_nxt = MUL_RUN;
            end else begin
              alu_load = 1'b1;
            end
          end
        end
        MUL_RUN: begin
          if (count == LAST_STEP) begin
            mul_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      zero_o  <= 1'b1;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      valid_o <= alu_load | mul_done;
      if (alu_load) begin
        data_o <= alu_res;
        zero_o <= (alu_res == '0);
      end else if (mul_done) begin
        data_o <= acc_nxt;
        zero_o <= (acc_nxt == '0);
      end
      if (mul_start) begin
        acc    <= '0;
        mcand  <= data1_i;
        mplier <= data2_i;
        count  <= '0;
      end else if (state == MUL_RUN && !flush_i) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  localparam logic [2:0] OP_RSV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i, data2_i;
  logic        flush_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        zero_o;

  alu_exec #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUCtrl_i(ALUCtrl_i),
    .data1_i(data1_i), .data2_i(data2_i), .flush_i(flush_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .zero_o(zero_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid_o pulse must match the oldest expected result.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got data 0x%08h expected no result", data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_data", data_o, e);
        check("sb_zero", {31'b0, zero_o}, {31'b0, (e == 32'h0)});
      end
    end
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic idle_inputs();
    valid_i = 1'b0; ALUCtrl_i = OP_RSV; data1_i = '0; data2_i = '0; flush_i = 1'b0;
  endtask

  // Drive a MUL at a negedge, wait for ready_o to return (bounded). Returns
  // the number of cycles ready_o was low.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         output int low_cycles);
    valid_i = 1'b1; ALUCtrl_i = OP_MUL; data1_i = a; data2_i = b;
    exp_q.push_back(exp);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    low_cycles = 0;
    while (ready_o === 1'b0 && low_cycles < 64) begin
      low_cycles++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    int lows;
    int early_valid;
    logic [31:0] held;

    vecs[0]  = '{"add_5_7",   OP_ADD, 32'd5,        32'd7,        32'd12};
    vecs[1]  = '{"sub_7_7",   OP_SUB, 32'd7,        32'd7,        32'd0};
    vecs[2]  = '{"xor",       OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F};
    vecs[3]  = '{"sll_31",    OP_SLL, 32'd1,        32'd31,       32'h80000000};
    vecs[4]  = '{"sra_neg",   OP_SRA, 32'h80000000, 32'd4,        32'hF8000000};
    vecs[5]  = '{"and",       OP_AND, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000};
    vecs[6]  = '{"sll_mask",  OP_SLL, 32'd1,        32'h00000021, 32'd2};
    vecs[7]  = '{"sra_pos",   OP_SRA, 32'h7FFFFFFF, 32'h00000021, 32'h3FFFFFFF};
    vecs[8]  = '{"add_wrap",  OP_ADD, 32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[9]  = '{"sub_wrap",  OP_SUB, 32'd0,        32'd1,        32'hFFFFFFFF};
    vecs[10] = '{"reserved",  OP_RSV, 32'h12345678, 32'h9ABCDEF0, 32'd0};

    idle_inputs();
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    check("rst_data",  data_o, 32'd0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_zero",  {31'b0, zero_o},  32'd1);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Back-to-back single-cycle stream: valid_o must be high every cycle.
    foreach (vecs[i]) begin
      valid_i = 1'b1; ALUCtrl_i = vecs[i].op; data1_i = vecs[i].a; data2_i = vecs[i].b;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk_i);
      @(negedge clk_i);
      check({"b2b_valid_", vecs[i].name}, {31'b0, valid_o}, 32'd1);
    end
    idle_inputs();
    @(negedge clk_i);
    check("valid_clears", {31'b0, valid_o}, 32'd0);
    check("data_holds",   data_o, 32'd0);

    // MUL timing with an ADD held on valid_i throughout MUL_RUN.
    valid_i = 1'b1; ALUCtrl_i = OP_MUL; data1_i = 32'hFFFFFFFF; data2_i = 32'd3;
    exp_q.push_back(32'hFFFFFFFD);
    @(posedge clk_i);
    @(negedge clk_i);
    ALUCtrl_i = OP_ADD; data1_i = 32'd5; data2_i = 32'd7;
    lows = 0; early_valid = 0;
    while (ready_o === 1'b0 && lows < 64) begin
      if (valid_o !== 1'b0) early_valid++;
      lows++;
      @(negedge clk_i);
    end
    check("mul_ready_low_cycles", lows, 32'd32);
    check("mul_no_early_valid", early_valid, 32'd0);
    check("mul_valid_at_32", {31'b0, valid_o}, 32'd1);
    exp_q.push_back(32'd12);  // held ADD is accepted on this first ready cycle
    @(posedge clk_i);
    @(negedge clk_i);
    check("add_after_mul_valid", {31'b0, valid_o}, 32'd1);
    idle_inputs();
    @(negedge clk_i);
    held = 32'd12;

    // Flush at cycle 10 of MUL 6*7: nothing produced, data_o held.
    valid_i = 1'b1; ALUCtrl_i = OP_MUL; data1_i = 32'd6; data2_i = 32'd7;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("flush10_busy", {31'b0, ready_o}, 32'd0);
    flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush10_ready", {31'b0, ready_o}, 32'd1);
    check("flush10_valid", {31'b0, valid_o}, 32'd0);
    check("flush10_data",  data_o, held);
    repeat (40) @(negedge clk_i);

    // Flush on the completing edge: result discarded.
    valid_i = 1'b1; ALUCtrl_i = OP_MUL; data1_i = 32'd6; data2_i = 32'd7;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (31) @(negedge clk_i);
    check("flushlast_busy", {31'b0, ready_o}, 32'd0);
    flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flushlast_ready", {31'b0, ready_o}, 32'd1);
    check("flushlast_valid", {31'b0, valid_o}, 32'd0);
    check("flushlast_data",  data_o, held);
    check("flushlast_zero",  {31'b0, zero_o}, 32'd0);
    repeat (3) @(negedge clk_i);

    // Async reset mid-MUL.
    valid_i = 1'b1; ALUCtrl_i = OP_MUL; data1_i = 32'd1234; data2_i = 32'd5678;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (14) @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("rstmul_ready", {31'b0, ready_o}, 32'd1);
    check("rstmul_valid", {31'b0, valid_o}, 32'd0);
    check("rstmul_data",  data_o, 32'd0);
    check("rstmul_zero",  {31'b0, zero_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (40) @(negedge clk_i);
    run_mul(32'd1234, 32'd5678, 32'd7006652, lows);
    check("mul2_ready_low_cycles", lows, 32'd32);
    @(negedge clk_i);
    run_mul(32'h00010000, 32'h00010000, 32'd0, lows);  // wraps to zero -> zero_o=1
    check("mul3_ready_low_cycles", lows, 32'd32);
    repeat (3) @(negedge clk_i);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
